// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the opcode SRAM read arbiter.
package sram_arb_pkg;

    localparam int unsigned ADDR_W = 8;
    localparam int unsigned DATA_W = 8;
    // Wide enough for the longest legal read latency (7).
    localparam int unsigned LAT_W  = 3;

    // FSM encoding
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACCESS = 1'b1;

    // Requester ids
    localparam logic REQ_FETCH = 1'b0;
    localparam logic REQ_DBG   = 1'b1;

    // Context of the access in flight.
    typedef struct packed {
        logic id;    // winning requester
        logic oor;   // latched address was out of range
        logic coll;  // load seen during the access
    } rd_ctx_t;

    // True when addr does not name a valid SRAM location.
    function automatic logic addr_oor(input logic [ADDR_W-1:0] addr,
                                      input int unsigned       max_addr);
        return {1'b0, addr} >= (ADDR_W + 1)'(max_addr);
    endfunction

endpackage

// File: rtl/sram_read_arbiter_rr_pick2.sv
// Two-way round-robin selector: a lone requester wins, a tie goes to the
// requester that was not granted last.
module rr_pick2
    import sram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       any,
    output logic       winner
);

    // Pick the winner for this cycle.
    always_comb begin
        any    = |req;
        winner = REQ_FETCH;
        if (req == 2'b11) begin
            winner = ~last_gnt;
        end else if (req[1]) begin
            winner = REQ_DBG;
        end
    end

endmodule

// File: rtl/sram_read_arbiter.sv
// Shares the opcode SRAM read port between the fetcher (port 0) and the
// debug reader (port 1). One read is in flight at a time; the response
// pulse lands in the first IDLE cycle, which may also start the next read.
module sram_read_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned MAX_ADDR = 8,
    // Cycles from address valid to data sampled; legal range 1..7.
    parameter int unsigned RD_LAT   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              err0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              err1,
    output logic              sram_load,
    output logic [ADDR_W-1:0] sram_address,
    input  logic [DATA_W-1:0] sram_data,
    output logic              busy
);

    logic [0:0]        state_q, state_d;
    logic              last_gnt_q, last_gnt_d;
    rd_ctx_t           ctx_q, ctx_d;
    logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [1:0]        err_q, err_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic              pick_any_c;
    logic              pick_winner_c;
    logic [ADDR_W-1:0] pick_addr_c;
    logic [DATA_W-1:0] rdata_cap_c;
    logic              last_beat_c;

    rr_pick2 u_pick (
        .req      ({req1, req0}),
        .last_gnt (last_gnt_q),
        .any      (pick_any_c),
        .winner   (pick_winner_c)
    );

    assign pick_addr_c = (pick_winner_c == REQ_DBG) ? addr1 : addr0;
    // Out-of-range reads return zero instead of whatever the SRAM drives.
    assign rdata_cap_c = ctx_q.oor ? '0 : sram_data;
    assign last_beat_c = (lat_cnt_q == LAT_W'(RD_LAT - 1));

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        last_gnt_d = last_gnt_q;
        ctx_d      = ctx_q;
        lat_cnt_d  = lat_cnt_q;
        addr_d     = addr_q;
        gnt_d      = 2'b00;
        rvalid_d   = 2'b00;
        err_d      = 2'b00;
        rdata0_d   = rdata0_q;
        rdata1_d   = rdata1_q;

        case (state_q)
            IDLE: begin
                if (!load && pick_any_c) begin
                    state_d    = ACCESS;
                    last_gnt_d = pick_winner_c;
                    ctx_d.id   = pick_winner_c;
                    ctx_d.oor  = addr_oor(pick_addr_c, MAX_ADDR);
                    ctx_d.coll = 1'b0;
                    lat_cnt_d  = '0;
                    gnt_d      = {pick_winner_c == REQ_DBG,
                                  pick_winner_c == REQ_FETCH};
                    // An invalid address never reaches the SRAM bus.
                    if (!addr_oor(pick_addr_c, MAX_ADDR)) begin
                        addr_d = pick_addr_c;
                    end
                end
            end
            ACCESS: begin
                ctx_d.coll = ctx_q.coll | load;
                if (last_beat_c) begin
                    state_d  = IDLE;
                    rvalid_d = {ctx_q.id == REQ_DBG, ctx_q.id == REQ_FETCH};
                    err_d    = {2{ctx_q.oor | ctx_q.coll | load}} & rvalid_d;
                    if (ctx_q.id == REQ_FETCH) begin
                        rdata0_d = rdata_cap_c;
                    end else begin
                        rdata1_d = rdata_cap_c;
                    end
                end else begin
                    lat_cnt_d = lat_cnt_q + LAT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset makes port 0 win the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_gnt_q <= REQ_DBG;
            ctx_q      <= '0;
            lat_cnt_q  <= '0;
            addr_q     <= '0;
            gnt_q      <= 2'b00;
            rvalid_q   <= 2'b00;
            err_q      <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            state_q    <= state_d;
            last_gnt_q <= last_gnt_d;
            ctx_q      <= ctx_d;
            lat_cnt_q  <= lat_cnt_d;
            addr_q     <= addr_d;
            gnt_q      <= gnt_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata0_q   <= rdata0_d;
            rdata1_q   <= rdata1_d;
        end
    end

    assign gnt0         = gnt_q[0];
    assign gnt1         = gnt_q[1];
    assign rvalid0      = rvalid_q[0];
    assign rvalid1      = rvalid_q[1];
    assign err0         = err_q[0];
    assign err1         = err_q[1];
    assign rdata0       = rdata0_q;
    assign rdata1       = rdata1_q;
    assign sram_address = addr_q;
    assign sram_load    = load;
    assign busy         = (state_q != IDLE) | load;

endmodule

// File: tb/tb_sram_read_arbiter.sv
// Bench for sram_read_arbiter: one instance at RD_LAT=1 and one at RD_LAT=3
// share the stimulus; sel chooses which one is observed.
module tb_sram_read_arbiter;

    logic       clk = 1'b0;
    logic       rst, load, req0, req1;
    logic [7:0] addr0, addr1;
    logic       sel;

    logic       a_gnt0, a_gnt1, a_rv0, a_rv1, a_err0, a_err1, a_sload, a_busy;
    logic [7:0] a_rd0, a_rd1, a_saddr, a_sdata;
    logic       b_gnt0, b_gnt1, b_rv0, b_rv1, b_err0, b_err1, b_sload, b_busy;
    logic [7:0] b_rd0, b_rd1, b_saddr, b_sdata;

    logic [1:0] o_gnt, o_rv, o_err;
    logic [7:0] o_rd0, o_rd1, o_saddr;
    logic       o_busy, o_sload;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // SRAM content model: mem[a] = a + 8'h10
    assign a_sdata = a_saddr + 8'h10;
    assign b_sdata = b_saddr + 8'h10;

    sram_read_arbiter #(.MAX_ADDR(8), .RD_LAT(1)) u_dut_l1 (
        .clk(clk), .rst(rst), .load(load),
        .req0(req0), .addr0(addr0), .gnt0(a_gnt0), .rvalid0(a_rv0), .rdata0(a_rd0), .err0(a_err0),
        .req1(req1), .addr1(addr1), .gnt1(a_gnt1), .rvalid1(a_rv1), .rdata1(a_rd1), .err1(a_err1),
        .sram_load(a_sload), .sram_address(a_saddr), .sram_data(a_sdata), .busy(a_busy)
    );

    sram_read_arbiter #(.MAX_ADDR(8), .RD_LAT(3)) u_dut_l3 (
        .clk(clk), .rst(rst), .load(load),
        .req0(req0), .addr0(addr0), .gnt0(b_gnt0), .rvalid0(b_rv0), .rdata0(b_rd0), .err0(b_err0),
        .req1(req1), .addr1(addr1), .gnt1(b_gnt1), .rvalid1(b_rv1), .rdata1(b_rd1), .err1(b_err1),
        .sram_load(b_sload), .sram_address(b_saddr), .sram_data(b_sdata), .busy(b_busy)
    );

    assign o_gnt   = sel ? {b_gnt1, b_gnt0} : {a_gnt1, a_gnt0};
    assign o_rv    = sel ? {b_rv1, b_rv0}   : {a_rv1, a_rv0};
    assign o_err   = sel ? {b_err1, b_err0} : {a_err1, a_err0};
    assign o_rd0   = sel ? b_rd0   : a_rd0;
    assign o_rd1   = sel ? b_rd1   : a_rd1;
    assign o_saddr = sel ? b_saddr : a_saddr;
    assign o_busy  = sel ? b_busy  : a_busy;
    assign o_sload = sel ? b_sload : a_sload;

    typedef struct {
        logic       rst, load, req0;
        logic [7:0] addr0;
        logic       req1;
        logic [7:0] addr1;
        logic [1:0] gnt, rv, err;   // {port1, port0}
        logic [7:0] rd0, rd1, saddr;
        logic       busy;
        bit         chk;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input int r, input int ld, input int q0, input int a0,
                                input int q1, input int a1, input int g, input int rv,
                                input int e, input int d0, input int d1, input int sa,
                                input int b, input int c);
        vec_t v;
        v.rst = 1'(r);   v.load = 1'(ld); v.req0 = 1'(q0); v.addr0 = 8'(a0);
        v.req1 = 1'(q1); v.addr1 = 8'(a1);
        v.gnt = 2'(g);   v.rv = 2'(rv);   v.err = 2'(e);
        v.rd0 = 8'(d0);  v.rd1 = 8'(d1);  v.saddr = 8'(sa);
        v.busy = 1'(b);  v.chk = (c != 0);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One reset cycle; returns at the start of cycle 0.
    task automatic do_reset();
        rst = 1'b1; load = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic cyc(input string tag, input logic [1:0] eg, input logic [1:0] erv);
        @(negedge clk);
        chk({tag, ".gnt"}, o_gnt, eg);
        chk({tag, ".rvalid"}, o_rv, erv);
    endtask

    // Transaction-level reference: arbitration decided at cycle c gives a grant
    // at c+1, an access window c+1..c+lat and a response at c+lat+1.
    task automatic run_random(input logic d, input int ncyc);
        int         lat, acc_first, acc_last, w;
        logic       cur_id, last, cur_oor, coll, in_acc, do_load;
        logic [7:0] cur_addr, exp_addr;
        logic [7:0] exp_rd [2];
        logic       known [2];
        logic       pend [2];
        logic [7:0] paddr [2];
        logic [1:0] eg, erv, eerr;
        lat = (d == 1'b0) ? 1 : 3;
        sel = d;
        do_reset();
        acc_first = -10; acc_last = -11; last = 1'b1; cur_id = 1'b0; cur_oor = 1'b0;
        coll = 1'b0; cur_addr = '0; exp_addr = '0;
        exp_rd = '{8'h00, 8'h00}; known = '{1'b1, 1'b1};
        pend = '{1'b0, 1'b0}; paddr = '{8'h00, 8'h00};
        for (int c = 0; c < ncyc; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pend[p]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        pend[p]  = 1'b1;
                        paddr[p] = 8'($urandom_range(0, 11));
                    end
                end else if ($urandom_range(0, 39) == 0) begin
                    pend[p] = 1'b0;   // withdrawal before grant
                end
            end
            do_load = ($urandom_range(0, 7) == 0);
            req0 = pend[0]; addr0 = paddr[0]; req1 = pend[1]; addr1 = paddr[1]; load = do_load;

            in_acc = (c >= acc_first) && (c <= acc_last);
            if (in_acc && do_load) coll = 1'b1;
            eg = 2'b00; erv = 2'b00; eerr = 2'b00;
            if (c == acc_first) eg[cur_id] = 1'b1;
            if (c == acc_last + 1) begin
                erv[cur_id]    = 1'b1;
                eerr[cur_id]   = cur_oor | coll;
                exp_rd[cur_id] = cur_oor ? 8'h00 : cur_addr + 8'h10;
                known[cur_id]  = !coll;
            end

            @(negedge clk);
            chk("rnd.gnt", o_gnt, eg);
            chk("rnd.rvalid", o_rv, erv);
            chk("rnd.err", o_err & erv, eerr);
            chk("rnd.busy", o_busy, in_acc | do_load);
            chk("rnd.sram_load", o_sload, do_load);
            chk("rnd.sram_address", o_saddr, exp_addr);
            if (known[0]) chk("rnd.rdata0", o_rd0, exp_rd[0]);
            if (known[1]) chk("rnd.rdata1", o_rd1, exp_rd[1]);

            if (!in_acc && !do_load && (pend[0] || pend[1])) begin
                if (pend[0] && pend[1]) w = last ? 0 : 1;
                else                    w = pend[1] ? 1 : 0;
                cur_id    = 1'(w);
                last      = 1'(w);
                cur_addr  = paddr[w];
                cur_oor   = (paddr[w] >= 8'd8);
                coll      = 1'b0;
                acc_first = c + 1;
                acc_last  = c + lat;
                if (!cur_oor) exp_addr = paddr[w];
                pend[w]   = 1'b0;
            end
            adv();
        end
        req0 = 1'b0; req1 = 1'b0; load = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ngr;
        sel = 1'b0;
        rst = 1'b1; load = 1'b0; req0 = 1'b0; req1 = 1'b0; addr0 = '0; addr1 = '0;

        // RD_LAT=1 vectors: rst,load,req0,addr0,req1,addr1 | gnt,rv,err,rd0,rd1,saddr,busy | chk
        // single read of address 3
        vq.push_back(mk(1,0, 0,'h00, 0,'h00, 0,0,0, 'h00,'h00,'h00, 0, 0));
        vq.push_back(mk(0,0, 1,'h03, 0,'h00, 0,0,0, 'h00,'h00,'h00, 0, 1));
        vq.push_back(mk(0,0, 1,'h03, 0,'h00, 1,0,0, 'h00,'h00,'h03, 1, 1));
        vq.push_back(mk(0,0, 0,'h03, 0,'h00, 0,1,0, 'h13,'h00,'h03, 0, 1));
        vq.push_back(mk(0,0, 0,'h03, 0,'h00, 0,0,0, 'h13,'h00,'h03, 0, 1));
        // contention from reset: port 0 first, then port 1
        vq.push_back(mk(1,0, 0,'h00, 0,'h00, 0,0,0, 'h00,'h00,'h00, 0, 0));
        vq.push_back(mk(0,0, 1,'h01, 1,'h02, 0,0,0, 'h00,'h00,'h00, 0, 1));
        vq.push_back(mk(0,0, 1,'h01, 1,'h02, 1,0,0, 'h00,'h00,'h01, 1, 1));
        vq.push_back(mk(0,0, 0,'h01, 1,'h02, 0,1,0, 'h11,'h00,'h01, 0, 1));
        vq.push_back(mk(0,0, 0,'h01, 1,'h02, 2,0,0, 'h11,'h00,'h02, 1, 1));
        vq.push_back(mk(0,0, 0,'h01, 0,'h02, 0,2,0, 'h11,'h12,'h02, 0, 1));
        // out-of-range read on port 1 after a valid read of 5
        vq.push_back(mk(1,0, 0,'h00, 0,'h00, 0,0,0, 'h00,'h00,'h00, 0, 0));
        vq.push_back(mk(0,0, 1,'h05, 0,'h00, 0,0,0, 'h00,'h00,'h00, 0, 1));
        vq.push_back(mk(0,0, 1,'h05, 0,'h00, 1,0,0, 'h00,'h00,'h05, 1, 1));
        vq.push_back(mk(0,0, 0,'h05, 1,'h08, 0,1,0, 'h15,'h00,'h05, 0, 1));
        vq.push_back(mk(0,0, 0,'h05, 1,'h08, 2,0,0, 'h15,'h00,'h05, 1, 1));
        vq.push_back(mk(0,0, 0,'h05, 0,'h08, 0,2,2, 'h15,'h00,'h05, 0, 1));
        // load holds off a pending request
        vq.push_back(mk(1,0, 0,'h00, 0,'h00, 0,0,0, 'h00,'h00,'h00, 0, 0));
        vq.push_back(mk(0,1, 1,'h02, 0,'h00, 0,0,0, 'h00,'h00,'h00, 1, 1));
        vq.push_back(mk(0,1, 1,'h02, 0,'h00, 0,0,0, 'h00,'h00,'h00, 1, 1));
        vq.push_back(mk(0,0, 1,'h02, 0,'h00, 0,0,0, 'h00,'h00,'h00, 0, 1));
        vq.push_back(mk(0,0, 1,'h02, 0,'h00, 1,0,0, 'h00,'h00,'h02, 1, 1));
        vq.push_back(mk(0,0, 0,'h02, 0,'h00, 0,1,0, 'h12,'h00,'h02, 0, 1));

        for (int i = 0; i < vq.size(); i++) begin
            rst = vq[i].rst; load = vq[i].load;
            req0 = vq[i].req0; addr0 = vq[i].addr0; req1 = vq[i].req1; addr1 = vq[i].addr1;
            @(negedge clk);
            if (vq[i].chk) begin
                chk($sformatf("vec%0d.gnt", i), o_gnt, vq[i].gnt);
                chk($sformatf("vec%0d.rvalid", i), o_rv, vq[i].rv);
                chk($sformatf("vec%0d.err", i), o_err & vq[i].rv, vq[i].err & vq[i].rv);
                chk($sformatf("vec%0d.rdata0", i), o_rd0, vq[i].rd0);
                chk($sformatf("vec%0d.rdata1", i), o_rd1, vq[i].rd1);
                chk($sformatf("vec%0d.sram_address", i), o_saddr, vq[i].saddr);
                chk($sformatf("vec%0d.busy", i), o_busy, vq[i].busy);
                chk($sformatf("vec%0d.sram_load", i), o_sload, vq[i].load);
            end
            adv();
        end

        // Fairness: both held, grants must alternate starting with port 0.
        sel = 1'b0;
        do_reset();
        req0 = 1'b1; addr0 = 8'h00; req1 = 1'b1; addr1 = 8'h01;
        ngr = 0;
        for (int k = 0; k < 40 && ngr < 8; k++) begin
            @(negedge clk);
            if (o_gnt != 2'b00) begin
                chk("fair.onehot", (o_gnt == 2'b11), 0);
                chk($sformatf("fair.grant%0d", ngr), o_gnt[1], ngr % 2);
                ngr++;
            end
            adv();
        end
        chk("fair.grant_count", ngr, 8);
        req0 = 1'b0; req1 = 1'b0;

        // RD_LAT=3: clean read of 6
        sel = 1'b1;
        do_reset();
        req0 = 1'b1; addr0 = 8'h06;
        cyc("l3.c0", 2'b00, 2'b00); chk("l3.c0.busy", o_busy, 0); adv();
        cyc("l3.c1", 2'b01, 2'b00); chk("l3.c1.sram_address", o_saddr, 8'h06); adv();
        req0 = 1'b0;
        cyc("l3.c2", 2'b00, 2'b00); chk("l3.c2.busy", o_busy, 1); adv();
        cyc("l3.c3", 2'b00, 2'b00); adv();
        cyc("l3.c4", 2'b00, 2'b01);
        chk("l3.c4.rdata0", o_rd0, 8'h16); chk("l3.c4.err0", o_err[0], 0);
        chk("l3.c4.busy", o_busy, 0);
        adv();

        // RD_LAT=3: load pulse inside the access window
        req0 = 1'b1; addr0 = 8'h04;
        cyc("coll.a0", 2'b00, 2'b00); adv();
        cyc("coll.a1", 2'b01, 2'b00); adv();
        req0 = 1'b0; load = 1'b1;
        cyc("coll.a2", 2'b00, 2'b00); chk("coll.a2.busy", o_busy, 1); chk("coll.a2.sram_load", o_sload, 1); adv();
        load = 1'b0;
        cyc("coll.a3", 2'b00, 2'b00); adv();
        cyc("coll.a4", 2'b00, 2'b01); chk("coll.a4.err0", o_err[0], 1); adv();

        // RD_LAT=3: reset in the grant cycle aborts the read
        req0 = 1'b1; addr0 = 8'h07;
        cyc("rst.a0", 2'b00, 2'b00); adv();
        rst = 1'b1; req0 = 1'b0;
        cyc("rst.a1", 2'b01, 2'b00); adv();
        rst = 1'b0;
        cyc("rst.a2", 2'b00, 2'b00);
        chk("rst.a2.rdata0", o_rd0, 8'h00); chk("rst.a2.rdata1", o_rd1, 8'h00);
        chk("rst.a2.sram_address", o_saddr, 8'h00); chk("rst.a2.busy", o_busy, 0);
        chk("rst.a2.err", o_err, 2'b00);
        adv();
        for (int k = 0; k < 6; k++) begin
            cyc($sformatf("rst.quiet%0d", k), 2'b00, 2'b00);
            adv();
        end
        req0 = 1'b1; addr0 = 8'h02;
        cyc("rst.n0", 2'b00, 2'b00); adv();
        cyc("rst.n1", 2'b01, 2'b00); adv();
        req0 = 1'b0;
        cyc("rst.n2", 2'b00, 2'b00); adv();
        cyc("rst.n3", 2'b00, 2'b00); adv();
        cyc("rst.n4", 2'b00, 2'b01);
        chk("rst.n4.rdata0", o_rd0, 8'h12); chk("rst.n4.err0", o_err[0], 0);
        adv();

        // Randomised traffic against the reference model, both latencies.
        run_random(1'b0, 400);
        run_random(1'b1, 400);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
